// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt controller: register map, FSM encoding
// and ID widths.
package irq_pkg;

    localparam int IRQ_ID_W        = 5;
    localparam int IRQ_MAX_SOURCES = 32;

    localparam logic [31:0] IRQ_REG_CTRL    = 32'd0;
    localparam logic [31:0] IRQ_REG_ENABLE  = 32'd1;
    localparam logic [31:0] IRQ_REG_PENDING = 32'd2;
    localparam logic [31:0] IRQ_REG_TRIGGER = 32'd3;
    localparam logic [31:0] IRQ_REG_STATUS  = 32'd4;
    localparam logic [31:0] IRQ_REG_EOI     = 32'd5;
    localparam logic [31:0] IRQ_REG_SWSET   = 32'd6;

    typedef enum logic [1:0] {
        IRQ_ST_IDLE       = 2'd0,
        IRQ_ST_ASSERT     = 2'd1,
        IRQ_ST_IN_SERVICE = 2'd2
    } irq_state_e;

    // True when the register index maps onto an implemented register.
    function automatic logic reg_in_range(input logic [31:0] idx);
        return (idx <= IRQ_REG_SWSET);
    endfunction

endpackage

// File: rtl/irq_priority_encoder.sv
// Combinational lowest-set-bit finder: index 0 has the highest priority.
module irq_priority_encoder
    import irq_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [W-1:0]        vec,
    output logic                valid,
    output logic [IRQ_ID_W-1:0] idx
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        valid = |vec;
        idx   = {IRQ_ID_W{1'b0}};
        for (int i = W - 1; i >= 0; i--) begin
            idx = vec[i] ? IRQ_ID_W'(i) : idx;
        end
    end

endmodule

// File: rtl/irq_controller_slave.sv
// Memory-mapped interrupt controller: latches peripheral interrupt lines as
// pending bits, arbitrates by fixed priority and hands one request to the core.
module irq_controller_slave
    import irq_pkg::*;
#(
    parameter int NUM_SOURCES = 8
) (
    input  logic                   i_Clk,
    input  logic                   i_Rst,
    input  logic                   i_WEnable,
    input  logic [31:0]            i_WAddr,
    input  logic [31:0]            i_WData,
    input  logic                   i_REnable,
    input  logic [31:0]            i_RAddr,
    output logic [31:0]            o_RData,
    output logic                   o_Err,
    input  logic [NUM_SOURCES-1:0] i_IrqSrc,
    input  logic                   i_IrqAck,
    output logic                   o_Irq,
    output logic [IRQ_ID_W-1:0]    o_IrqId
);

    localparam int N = NUM_SOURCES;

    logic                gie_r;
    logic [N-1:0]        enable_r;
    logic [N-1:0]        pending_r;
    logic [N-1:0]        trigger_r;
    logic [N-1:0]        prev_r;
    irq_state_e          state_r;
    irq_state_e          state_nxt_s;
    logic [IRQ_ID_W-1:0] irq_id_r;
    logic                irq_r;
    logic [31:0]         rdata_r;
    logic                err_r;

    logic [N-1:0]        wdata_s;
    logic                wr_ok_s;
    logic                wr_ctrl_s;
    logic                wr_enable_s;
    logic                wr_pending_s;
    logic                wr_trigger_s;
    logic                wr_eoi_s;
    logic                wr_swset_s;
    logic [31:0]         rd_mux_s;

    logic [N-1:0]        hw_set_s;
    logic [N-1:0]        sw_set_s;
    logic [N-1:0]        w1c_s;
    logic [N-1:0]        id_onehot_s;
    logic                ack_take_s;
    logic [N-1:0]        ack_clr_s;
    logic [N-1:0]        pending_nxt_s;
    logic [N-1:0]        eligible_s;
    logic                id_eligible_s;
    logic                win_valid_s;
    logic [IRQ_ID_W-1:0] win_idx_s;
    logic                id_load_s;

    // Upper write-data bits beyond the source count carry no meaning.
    if (N < 32) begin : g_unused_wdata
        logic unused_wdata_s;
        assign unused_wdata_s = ^i_WData[31:N];
    end

    assign wdata_s      = i_WData[N-1:0];
    assign wr_ok_s      = i_WEnable && reg_in_range(i_WAddr) && (i_WAddr != IRQ_REG_STATUS);
    assign wr_ctrl_s    = wr_ok_s && (i_WAddr == IRQ_REG_CTRL);
    assign wr_enable_s  = wr_ok_s && (i_WAddr == IRQ_REG_ENABLE);
    assign wr_pending_s = wr_ok_s && (i_WAddr == IRQ_REG_PENDING);
    assign wr_trigger_s = wr_ok_s && (i_WAddr == IRQ_REG_TRIGGER);
    assign wr_eoi_s     = wr_ok_s && (i_WAddr == IRQ_REG_EOI);
    assign wr_swset_s   = wr_ok_s && (i_WAddr == IRQ_REG_SWSET);

    // Read mux over the register map; write-only registers read as zero.
    always_comb begin
        rd_mux_s = 32'd0;
        case (i_RAddr)
            IRQ_REG_CTRL:    rd_mux_s = {31'd0, gie_r};
            IRQ_REG_ENABLE:  rd_mux_s = 32'(enable_r);
            IRQ_REG_PENDING: rd_mux_s = 32'(pending_r);
            IRQ_REG_TRIGGER: rd_mux_s = 32'(trigger_r);
            IRQ_REG_STATUS:  rd_mux_s = {25'd0, state_r, irq_id_r};
            default:         rd_mux_s = 32'd0;
        endcase
    end

    // Bus response: write wins over read, an error leaves read data untouched.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            rdata_r <= 32'd0;
            err_r   <= 1'b0;
        end else if (i_WEnable) begin
            err_r <= !wr_ok_s;
        end else if (i_REnable) begin
            if (reg_in_range(i_RAddr)) begin
                rdata_r <= rd_mux_s;
                err_r   <= 1'b0;
            end else begin
                err_r <= 1'b1;
            end
        end
    end

    // Software-visible configuration registers.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            gie_r     <= 1'b0;
            enable_r  <= {N{1'b0}};
            trigger_r <= {N{1'b0}};
        end else begin
            if (wr_ctrl_s)    gie_r     <= i_WData[0];
            if (wr_enable_s)  enable_r  <= wdata_s;
            if (wr_trigger_s) trigger_r <= wdata_s;
        end
    end

    // One-hot view of the presented ID, used for the ack clear and the
    // still-eligible check.
    always_comb begin
        id_onehot_s = {N{1'b0}};
        for (int i = 0; i < N; i++) begin
            id_onehot_s[i] = (irq_id_r == IRQ_ID_W'(i));
        end
    end

    // Set sources win over clears on the same bit, so a level line that is
    // still high when acknowledged re-pends immediately.
    always_comb begin
        hw_set_s      = (i_IrqSrc & ~prev_r & trigger_r) | (i_IrqSrc & ~trigger_r);
        sw_set_s      = wr_swset_s ? wdata_s : {N{1'b0}};
        w1c_s         = wr_pending_s ? wdata_s : {N{1'b0}};
        ack_take_s    = (state_r == IRQ_ST_ASSERT) && i_IrqAck;
        ack_clr_s     = ack_take_s ? id_onehot_s : {N{1'b0}};
        pending_nxt_s = (pending_r & ~(w1c_s | ack_clr_s)) | hw_set_s | sw_set_s;
    end

    // Edge-detect history and pending latch; history reloads on reset so the
    // first cycle after reset sees no phantom edge.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            prev_r    <= i_IrqSrc;
            pending_r <= {N{1'b0}};
        end else begin
            prev_r    <= i_IrqSrc;
            pending_r <= pending_nxt_s;
        end
    end

    assign eligible_s    = pending_r & enable_r;
    assign id_eligible_s = |(eligible_s & id_onehot_s);

    irq_priority_encoder #(
        .W (N)
    ) u_prio (
        .vec   (eligible_s),
        .valid (win_valid_s),
        .idx   (win_idx_s)
    );

    // Request/acknowledge/end-of-interrupt sequencing; no preemption while
    // a source is in service.
    always_comb begin
        state_nxt_s = state_r;
        id_load_s   = 1'b0;
        case (state_r)
            IRQ_ST_IDLE: begin
                if (gie_r && win_valid_s) begin
                    state_nxt_s = IRQ_ST_ASSERT;
                    id_load_s   = 1'b1;
                end else begin
                    state_nxt_s = IRQ_ST_IDLE;
                end
            end
            IRQ_ST_ASSERT: begin
                if (i_IrqAck) begin
                    state_nxt_s = IRQ_ST_IN_SERVICE;
                end else if (!gie_r || !id_eligible_s) begin
                    state_nxt_s = IRQ_ST_IDLE;
                end else begin
                    state_nxt_s = IRQ_ST_ASSERT;
                end
            end
            IRQ_ST_IN_SERVICE: begin
                if (wr_eoi_s) begin
                    state_nxt_s = IRQ_ST_IDLE;
                end else begin
                    state_nxt_s = IRQ_ST_IN_SERVICE;
                end
            end
            default: begin
                state_nxt_s = IRQ_ST_IDLE;
            end
        endcase
    end

    // FSM state, registered request line and latched source ID.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_r  <= IRQ_ST_IDLE;
            irq_r    <= 1'b0;
            irq_id_r <= {IRQ_ID_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            irq_r   <= (state_nxt_s == IRQ_ST_ASSERT);
            if (id_load_s) irq_id_r <= win_idx_s;
        end
    end

    assign o_RData = rdata_r;
    assign o_Err   = err_r;
    assign o_Irq   = irq_r;
    assign o_IrqId = irq_id_r;

endmodule
